// File: rtl/path_delay_meter_if.sv
// Host-side bundle of the path delay meter: run control and the result handshake.
// The meter connects through the slave modport; the host readout logic connects through master.
interface path_delay_meter_if #(
  parameter int CNT_W    = 16,
  parameter int TRIALS_W = 8
);
  logic                      start;
  logic [TRIALS_W-1:0]       trials;
  logic                      busy;
  logic                      result_valid;
  logic                      result_ready;
  logic [CNT_W+TRIALS_W-1:0] delay_sum;
  logic [CNT_W-1:0]          delay_min;
  logic [CNT_W-1:0]          delay_max;
  logic [TRIALS_W-1:0]       trials_done;
  logic                      timeout_err;

  modport master (
    output start, trials, result_ready,
    input  busy, result_valid, delay_sum, delay_min, delay_max, trials_done, timeout_err
  );

  modport slave (
    input  start, trials, result_ready,
    output busy, result_valid, delay_sum, delay_min, delay_max, trials_done, timeout_err
  );
endinterface

// File: rtl/path_delay_meter.sv
// Launches alternating transitions into a delay path and times their arrival through a
// synchronizer, accumulating sum/min/max of the per-trial delay for the host.
module path_delay_meter #(
  parameter int CNT_W         = 16,
  parameter int TRIALS_W      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 64,
  parameter int TIMEOUT       = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  path_delay_meter_if.slave   host,
  output logic                path_launch,
  input  logic                path_capture
);

  localparam int SUM_W    = CNT_W + TRIALS_W;
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    TIMEOUT_C   = CNT_W'(TIMEOUT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_LAUNCH  = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_ACCUM   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  function automatic logic [CNT_W-1:0] min_of(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [CNT_W-1:0] max_of(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [2:0]             state;
  logic [SETTLE_W-1:0]    settle_cnt;
  logic [CNT_W-1:0]       cnt;
  logic [TRIALS_W-1:0]    trials_lat;
  logic [TRIALS_W-1:0]    trials_done_r;
  logic [TRIALS_W-1:0]    trials_next;
  logic [SUM_W-1:0]       delay_sum_r;
  logic [CNT_W-1:0]       delay_min_r;
  logic [CNT_W-1:0]       delay_max_r;
  logic                   busy_r;
  logic                   result_valid_r;
  logic                   timeout_err_r;
  logic [SYNC_STAGES-1:0] sync_p;
  logic                   target;
  logic                   match;

  // Capture synchronizer: path_capture is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], path_capture};
    end
  end

  // Even trials launch rising, odd trials falling; the completed-trial count picks the level
  assign target      = ~trials_done_r[0];
  assign match       = (sync_p[SYNC_STAGES-1] == target);
  assign trials_next = trials_done_r + TRIALS_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      settle_cnt     <= '0;
      cnt            <= '0;
      trials_lat     <= '0;
      trials_done_r  <= '0;
      delay_sum_r    <= '0;
      delay_min_r    <= '1;
      delay_max_r    <= '0;
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
      timeout_err_r  <= 1'b0;
      path_launch    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (host.start) begin
            trials_lat    <= host.trials;
            trials_done_r <= '0;
            delay_sum_r   <= '0;
            delay_min_r   <= '1;
            delay_max_r   <= '0;
            timeout_err_r <= 1'b0;
            settle_cnt    <= '0;
            if (host.trials == '0) begin
              state          <= S_DONE;
              result_valid_r <= 1'b1;
            end else begin
              state  <= S_SETTLE;
              busy_r <= 1'b1;
            end
          end
        end

        S_SETTLE: begin
          // Park the path at the pre-launch level; after a timeout it may be left opposite
          path_launch <= trials_done_r[0];
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_LAUNCH;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
        end

        S_LAUNCH: begin
          path_launch <= target;
          cnt         <= '0;
          state       <= S_MEASURE;
        end

        S_MEASURE: begin
          // cnt already holds the edge count at which the last stage took the target level
          if (match) begin
            state <= S_ACCUM;
          end else if (cnt == TIMEOUT_C) begin
            timeout_err_r  <= 1'b1;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b1;
            state          <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_ACCUM: begin
          delay_sum_r   <= delay_sum_r + SUM_W'(cnt);
          delay_min_r   <= min_of(delay_min_r, cnt);
          delay_max_r   <= max_of(delay_max_r, cnt);
          trials_done_r <= trials_next;
          settle_cnt    <= '0;
          if (trials_next == trials_lat) begin
            busy_r         <= 1'b0;
            result_valid_r <= 1'b1;
            state          <= S_DONE;
          end else begin
            state <= S_SETTLE;
          end
        end

        S_DONE: begin
          if (host.result_ready) begin
            result_valid_r <= 1'b0;
            state          <= S_IDLE;
          end
        end

        default: begin
          state          <= S_IDLE;
          busy_r         <= 1'b0;
          result_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign host.busy         = busy_r;
  assign host.result_valid = result_valid_r;
  assign host.delay_sum    = delay_sum_r;
  assign host.delay_min    = delay_min_r;
  assign host.delay_max    = delay_max_r;
  assign host.trials_done  = trials_done_r;
  assign host.timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_path_delay_meter.sv
// Bench for path_delay_meter: drives a configurable delay line on the path and compares
// results against a per-trial arithmetic model of the expected delays.
module tb_path_delay_meter;
  localparam int CNT_W    = 16;
  localparam int TRIALS_W = 8;
  localparam int SYNC     = 2;
  localparam int SETTLE   = 64;
  localparam int TMO      = 1024;
  localparam logic [CNT_W-1:0] ONES = '1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic path_launch;
  logic path_capture;
  logic [7:0] dl_reg = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int mode     = 0;   // 0: delay line with taps, 2: capture tied low
  int rise_tap = 0;
  int fall_tap = 0;

  always #5 clk = ~clk;

  path_delay_meter_if #(.CNT_W(CNT_W), .TRIALS_W(TRIALS_W)) host();

  path_delay_meter #(
    .CNT_W(CNT_W), .TRIALS_W(TRIALS_W), .SYNC_STAGES(SYNC),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .host(host),
    .path_launch(path_launch), .path_capture(path_capture)
  );

  // Path under test: a register chain whose tap depends on the launched direction
  always @(posedge clk) dl_reg <= {dl_reg[6:0], path_launch};

  always_comb begin
    int tap;
    tap = path_launch ? rise_tap : fall_tap;
    path_capture = path_launch;
    if (mode == 2) path_capture = 1'b0;
    else if (tap != 0) path_capture = dl_reg[tap-1];
  end

  function automatic void model(input int t, input int rt, input int ft,
                                output longint sum, output int mn, output int mx);
    int d;
    sum = 0; mn = 65535; mx = 0;
    for (int i = 0; i < t; i++) begin
      d = SYNC + (((i % 2) == 0) ? rt : ft);
      sum += d;
      if (d < mn) mn = d;
      if (d > mx) mx = d;
    end
  endfunction

  task automatic pulse_start(input int t);
    @(negedge clk);
    host.start  = 1'b1;
    host.trials = TRIALS_W'(t);
    @(negedge clk);
    host.start  = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok, output int cycles);
    cycles = 0;
    while (cycles < budget && host.result_valid !== 1'b1) begin
      @(negedge clk);
      cycles++;
    end
    ok = (host.result_valid === 1'b1);
  endtask

  task automatic ack();
    @(negedge clk); host.result_ready = 1'b1;
    @(negedge clk); host.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (path_launch !== 1'b0) begin n_fail++; $display("FAIL reset_launch: got %b expected 0", path_launch); end
    n_tests++; if ({host.busy, host.result_valid, host.timeout_err} !== 3'b000) begin n_fail++;
      $display("FAIL reset_flags: busy/valid/err got %b%b%b expected 000", host.busy, host.result_valid, host.timeout_err); end
    n_tests++; if (host.delay_sum !== '0 || host.delay_max !== '0 || host.trials_done !== '0) begin n_fail++;
      $display("FAIL reset_results: sum %0d max %0d done %0d expected 0", host.delay_sum, host.delay_max, host.trials_done); end
    n_tests++; if (host.delay_min !== ONES) begin n_fail++; $display("FAIL reset_min: got %h expected %h", host.delay_min, ONES); end
    rst_n = 1'b1;
  endtask

  task automatic test_loopback();
    int toggles, gap, min_gap, cyc;
    logic last;
    mode = 0; rise_tap = 0; fall_tap = 0;
    pulse_start(4);
    n_tests++; if (host.busy !== 1'b1) begin n_fail++; $display("FAIL loop_busy: got %b expected 1", host.busy); end
    toggles = 0; gap = 0; min_gap = 1000000; cyc = 0; last = path_launch;
    while (cyc < 2000 && host.result_valid !== 1'b1) begin
      @(negedge clk); cyc++;
      if (path_launch !== last) begin toggles++; if (gap < min_gap) min_gap = gap; gap = 0; end
      else gap++;
      last = path_launch;
    end
    n_tests++; if (host.result_valid !== 1'b1) begin n_fail++; $display("FAIL loop_valid: got %b expected 1", host.result_valid); end
    n_tests++; if (host.delay_sum !== 24'd8) begin n_fail++; $display("FAIL loop_sum: got %0d expected 8", host.delay_sum); end
    n_tests++; if (host.delay_min !== 16'd2 || host.delay_max !== 16'd2) begin n_fail++;
      $display("FAIL loop_minmax: got %0d/%0d expected 2/2", host.delay_min, host.delay_max); end
    n_tests++; if (host.trials_done !== 8'd4 || host.timeout_err !== 1'b0 || host.busy !== 1'b0) begin n_fail++;
      $display("FAIL loop_status: done %0d err %b busy %b expected 4 0 0", host.trials_done, host.timeout_err, host.busy); end
    n_tests++; if (toggles != 4 || min_gap < SETTLE) begin n_fail++;
      $display("FAIL loop_launches: toggles %0d min gap %0d expected 4 and >=%0d", toggles, min_gap, SETTLE); end
    ack();
  endtask

  task automatic test_zero_trials();
    bit ok; int cyc;
    pulse_start(0);
    wait_valid(2, ok, cyc);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL zero_valid: got %b expected 1 within 2 cycles", host.result_valid); end
    n_tests++; if (host.delay_sum !== '0 || host.delay_max !== '0 || host.trials_done !== '0 || host.delay_min !== ONES || host.timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL zero_results: sum %0d min %h max %0d done %0d err %b expected reset values",
        host.delay_sum, host.delay_min, host.delay_max, host.trials_done, host.timeout_err); end
    n_tests++; if (path_launch !== 1'b0) begin n_fail++; $display("FAIL zero_launch: got %b expected 0", path_launch); end
    ack();
  endtask

  task automatic test_asym_delay();
    bit ok; int cyc;
    mode = 0; rise_tap = 5; fall_tap = 3;
    pulse_start(3);
    wait_valid(2000, ok, cyc);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL asym_valid: got %b expected 1", host.result_valid); end
    n_tests++; if (host.delay_sum !== 24'd19) begin n_fail++; $display("FAIL asym_sum: got %0d expected 19", host.delay_sum); end
    n_tests++; if (host.delay_min !== 16'd5 || host.delay_max !== 16'd7) begin n_fail++;
      $display("FAIL asym_minmax: got %0d/%0d expected 5/7", host.delay_min, host.delay_max); end
    n_tests++; if (host.trials_done !== 8'd3) begin n_fail++; $display("FAIL asym_done: got %0d expected 3", host.trials_done); end
    ack();
  endtask

  task automatic test_random();
    bit ok; int cyc, t, mn, mx; longint sum;
    for (int it = 0; it < 5; it++) begin
      mode = 0;
      t = $urandom_range(1, 5);
      rise_tap = $urandom_range(0, 8);
      fall_tap = $urandom_range(0, 8);
      model(t, rise_tap, fall_tap, sum, mn, mx);
      pulse_start(t);
      wait_valid(2500, ok, cyc);
      n_tests++; if (!ok || host.delay_sum !== 24'(sum)) begin n_fail++;
        $display("FAIL rand_sum[%0d]: got %0d expected %0d (t=%0d r=%0d f=%0d)", it, host.delay_sum, sum, t, rise_tap, fall_tap); end
      n_tests++; if (host.delay_min !== 16'(mn) || host.delay_max !== 16'(mx)) begin n_fail++;
        $display("FAIL rand_minmax[%0d]: got %0d/%0d expected %0d/%0d", it, host.delay_min, host.delay_max, mn, mx); end
      n_tests++; if (host.trials_done !== 8'(t) || host.timeout_err !== 1'b0) begin n_fail++;
        $display("FAIL rand_done[%0d]: done %0d err %b expected %0d 0", it, host.trials_done, host.timeout_err, t); end
      ack();
    end
  endtask

  task automatic test_timeout();
    bit ok; int cyc;
    mode = 2;
    pulse_start(2);
    wait_valid(2000, ok, cyc);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL tmo_valid: got %b expected 1", host.result_valid); end
    n_tests++; if (host.timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b expected 1", host.timeout_err); end
    n_tests++; if (host.trials_done !== '0 || host.delay_sum !== '0 || host.delay_max !== '0 || host.delay_min !== ONES) begin n_fail++;
      $display("FAIL tmo_results: done %0d sum %0d min %h max %0d expected 0 0 ffff 0", host.trials_done, host.delay_sum, host.delay_min, host.delay_max); end
    n_tests++; if (cyc < TMO + SETTLE || cyc > TMO + SETTLE + 50) begin n_fail++;
      $display("FAIL tmo_latency: got %0d cycles expected about %0d", cyc, TMO + SETTLE); end
    ack();
    mode = 0;
  endtask

  task automatic test_done_hold();
    bit ok; int cyc;
    mode = 0; rise_tap = 0; fall_tap = 0;
    pulse_start(2);
    wait_valid(2000, ok, cyc);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL hold_valid: got %b expected 1", host.result_valid); end
    for (int i = 0; i < 20; i++) begin
      host.start  = 1'($urandom_range(0, 1));
      host.trials = TRIALS_W'($urandom_range(0, 7));
      @(negedge clk);
      n_tests++; if (host.result_valid !== 1'b1 || host.delay_sum !== 24'd4 || host.delay_min !== 16'd2 ||
                     host.delay_max !== 16'd2 || host.trials_done !== 8'd2 || host.busy !== 1'b0) begin n_fail++;
        $display("FAIL hold_stable[%0d]: valid %b sum %0d min %0d max %0d done %0d busy %b expected 1 4 2 2 2 0",
          i, host.result_valid, host.delay_sum, host.delay_min, host.delay_max, host.trials_done, host.busy); end
    end
    host.start = 1'b0;
    ack();
    n_tests++; if (host.result_valid !== 1'b0 || host.delay_sum !== 24'd4) begin n_fail++;
      $display("FAIL hold_release: valid %b sum %0d expected 0 4", host.result_valid, host.delay_sum); end
    pulse_start(1);
    n_tests++; if (host.delay_sum !== '0 || host.trials_done !== '0 || host.delay_min !== ONES || host.busy !== 1'b1) begin n_fail++;
      $display("FAIL hold_restart: sum %0d done %0d min %h busy %b expected 0 0 ffff 1", host.delay_sum, host.trials_done, host.delay_min, host.busy); end
    wait_valid(2000, ok, cyc);
    n_tests++; if (!ok || host.delay_sum !== 24'd2 || host.trials_done !== 8'd1) begin n_fail++;
      $display("FAIL hold_rerun: sum %0d done %0d expected 2 1", host.delay_sum, host.trials_done); end
    ack();
  endtask

  task automatic test_async_reset();
    bit ok; int cyc;
    mode = 2;
    pulse_start(1);
    cyc = 0;
    while (cyc < 200 && path_launch !== 1'b1) begin @(negedge clk); cyc++; end
    n_tests++; if (path_launch !== 1'b1) begin n_fail++; $display("FAIL areset_launched: got %b expected 1", path_launch); end
    repeat (10) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_tests++; if ({path_launch, host.busy, host.result_valid} !== 3'b000) begin n_fail++;
      $display("FAIL areset_immediate: launch/busy/valid got %b%b%b expected 000", path_launch, host.busy, host.result_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mode = 0; rise_tap = 0; fall_tap = 0;
    @(negedge clk);
    n_tests++; if (host.result_valid !== 1'b0 || host.busy !== 1'b0) begin n_fail++;
      $display("FAIL areset_idle: valid %b busy %b expected 0 0", host.result_valid, host.busy); end
    pulse_start(2);
    wait_valid(2000, ok, cyc);
    n_tests++; if (!ok || host.delay_sum !== 24'd4 || host.delay_min !== 16'd2 || host.delay_max !== 16'd2 ||
                   host.trials_done !== 8'd2 || host.timeout_err !== 1'b0) begin n_fail++;
      $display("FAIL areset_rerun: sum %0d min %0d max %0d done %0d err %b expected 4 2 2 2 0",
        host.delay_sum, host.delay_min, host.delay_max, host.trials_done, host.timeout_err); end
    ack();
  endtask

  initial begin
    host.start        = 1'b0;
    host.trials       = '0;
    host.result_ready = 1'b0;
    test_reset();
    test_loopback();
    test_zero_trials();
    test_asym_delay();
    test_random();
    test_timeout();
    test_done_hold();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
